// File: rtl/ifu_fetch.sv
// ---------------------------------------------------------------------------
// ifu_fetch : instruction-fetch stage of the P7 five-stage MIPS pipeline.
//
// Owns the architectural fetch PC, drives the instruction-memory address and
// presents pc_F / instr_F / BD_F / adEL_F to the F/D pipeline register.
// Next-PC priority: reset, exception entry (req), stall, ERET, D redirect, +4.
//
// Optional feature (macro IFU_RANGE_CHECK_EN):
//   defined   - adEL_F also flags fetch addresses outside [IM_LO, IM_HI]
//   undefined - only misaligned fetch addresses raise adEL_F
//
// Ports:
//   clk              in   clock, rising edge
//   reset            in   synchronous active-high reset
//   stall            in   hazard stall from D, holds the PC
//   req              in   CP0 exception/interrupt request, overrides stall
//   eret_D           in   ERET in D
//   epc              in   [31:0] ERET return address
//   redirect_D       in   taken branch/jump resolved in D
//   redirect_target  in   [31:0] branch/jump target
//   branch_D         in   any branch/jump in D (delay-slot marker)
//   i_inst_rdata     in   [31:0] instruction memory read data
//   i_inst_addr      out  [31:0] word-aligned instruction memory address
//   pc_F             out  [31:0] current fetch PC
//   instr_F          out  [31:0] fetched instruction, 0 when squashed/faulting
//   BD_F             out  fetched instruction sits in a delay slot
//   adEL_F           out  fetch address error
//   fetch_count      out  [31:0] valid instructions handed to F/D
// ---------------------------------------------------------------------------
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] EXC_PC   = 32'h0000_4180,
  parameter logic [31:0] IM_LO    = 32'h0000_3000,
  parameter logic [31:0] IM_HI    = 32'h0000_6ffc
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        req,
  input  logic        eret_D,
  input  logic [31:0] epc,
  input  logic        redirect_D,
  input  logic [31:0] redirect_target,
  input  logic        branch_D,
  input  logic [31:0] i_inst_rdata,
  output logic [31:0] i_inst_addr,
  output logic [31:0] pc_F,
  output logic [31:0] instr_F,
  output logic        BD_F,
  output logic        adEL_F,
  output logic [31:0] fetch_count
);

  localparam int unsigned W = 32;

`ifdef IFU_RANGE_CHECK_EN
  localparam logic RANGE_EN = 1'b1;
`else
  localparam logic RANGE_EN = 1'b0;
`endif

  logic [W-1:0] r_pc;
  logic [W-1:0] r_fetch_count;
  logic [W-1:0] w_pc_next;
  logic         w_misalign;
  logic         w_range_err;
  logic         w_addr_err;
  logic         w_count_en;

  // Address fault detection on the current fetch PC
  assign w_misalign  = (r_pc[1:0] != 2'b00);
  assign w_range_err = RANGE_EN & ((r_pc < IM_LO) | (r_pc > IM_HI));
  assign w_addr_err  = w_misalign | w_range_err;

  // Memory address is always word-aligned, even while a misalignment is reported
  assign i_inst_addr = {r_pc[W-1:2], 2'b00};
  assign pc_F        = r_pc;
  assign fetch_count = r_fetch_count;

  // ERET has no delay slot: the wrong-path fetch becomes a clean bubble
  always_comb begin
    instr_F = i_inst_rdata;
    BD_F    = branch_D;
    adEL_F  = w_addr_err;
    if (eret_D) begin
      instr_F = '0;
      BD_F    = 1'b0;
      adEL_F  = 1'b0;
    end else if (w_addr_err) begin
      instr_F = '0;
    end
  end

  // Next-PC selection; reset is handled in the register itself
  always_comb begin
    w_pc_next = r_pc + W'(4);
    if (req) begin
      w_pc_next = EXC_PC;
    end else if (stall) begin
      w_pc_next = r_pc;
    end else if (eret_D) begin
      w_pc_next = epc;
    end else if (redirect_D) begin
      w_pc_next = redirect_target;
    end
  end

  // Count only instructions that really proceed into F/D
  assign w_count_en = ~req & ~stall & ~eret_D & ~adEL_F;

  // PC and fetch counter state
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc          <= RESET_PC;
      r_fetch_count <= '0;
    end else begin
      r_pc <= w_pc_next;
      if (w_count_en) begin
        r_fetch_count <= r_fetch_count + W'(1);
      end
    end
  end

endmodule

// File: tb/tb_ifu_fetch.sv
module tb_ifu_fetch;

  localparam logic [31:0] K = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        reset, stall, req, eret_D, redirect_D, branch_D;
  logic [31:0] epc, redirect_target;
  logic [31:0] i_inst_rdata, i_inst_addr, pc_F, instr_F, fetch_count;
  logic        BD_F, adEL_F;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_fc;

`ifdef IFU_RANGE_CHECK_EN
  localparam logic RC = 1'b1;
`else
  localparam logic RC = 1'b0;
`endif

  always #5 clk = ~clk;

  // Instruction memory model: data is a fixed function of the word address
  assign i_inst_rdata = i_inst_addr ^ K;

  ifu_fetch dut (
    .clk(clk), .reset(reset), .stall(stall), .req(req), .eret_D(eret_D),
    .epc(epc), .redirect_D(redirect_D), .redirect_target(redirect_target),
    .branch_D(branch_D), .i_inst_rdata(i_inst_rdata), .i_inst_addr(i_inst_addr),
    .pc_F(pc_F), .instr_F(instr_F), .BD_F(BD_F), .adEL_F(adEL_F),
    .fetch_count(fetch_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle away from it
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    stall = 0; req = 0; eret_D = 0; redirect_D = 0; branch_D = 0;
  endtask

  initial begin
    reset = 1; epc = '0; redirect_target = '0;
    idle();
    tick();
    reset = 0;
    #1;
    // Reset state
    chk("rst_pc", pc_F, 32'h3000);
    chk("rst_addr", i_inst_addr, 32'h3000);
    chk("rst_adel", 32'(adEL_F), 32'd0);
    chk("rst_fc", fetch_count, 32'd0);
    chk("rst_instr", instr_F, 32'h3000 ^ K);
    branch_D = 1; #1;
    chk("rst_bd1", 32'(BD_F), 32'd1);
    branch_D = 0; #1;
    chk("rst_bd0", 32'(BD_F), 32'd0);

    // Sequential fetch
    tick(); chk("seq_pc1", pc_F, 32'h3004);
    tick(); chk("seq_pc2", pc_F, 32'h3008);
    tick(); chk("seq_pc3", pc_F, 32'h300c);
    chk("seq_fc3", fetch_count, 32'd3);
    chk("seq_instr", instr_F, 32'h300c ^ K);
    tick(); chk("seq_pc4", pc_F, 32'h3010);

    // Taken branch from D
    branch_D = 1; redirect_D = 1; redirect_target = 32'h3100; #1;
    chk("br_bd", 32'(BD_F), 32'd1);
    chk("br_pc", pc_F, 32'h3010);
    tick(); idle(); #1;
    chk("br_tgt", pc_F, 32'h3100);
    chk("br_bd0", 32'(BD_F), 32'd0);
    chk("br_fc", fetch_count, 32'd5);

    // Move to 0x3020, stall twice, then exception under stall
    redirect_D = 1; redirect_target = 32'h3020;
    tick(); idle(); #1;
    chk("st_pc0", pc_F, 32'h3020);
    chk("st_fc0", fetch_count, 32'd6);
    stall = 1;
    tick(); chk("st_pc1", pc_F, 32'h3020);
    tick(); chk("st_pc2", pc_F, 32'h3020);
    req = 1; redirect_D = 1; redirect_target = 32'h3300;
    tick(); idle(); #1;
    chk("exc_pc", pc_F, 32'h4180);
    chk("exc_fc", fetch_count, 32'd6);

    // ERET beats redirect and squashes the wrong-path fetch
    tick(); chk("h_pc1", pc_F, 32'h4184);
    tick(); chk("h_pc2", pc_F, 32'h4188);
    chk("h_fc", fetch_count, 32'd8);
    eret_D = 1; epc = 32'h3040; redirect_D = 1; redirect_target = 32'h3200; branch_D = 1; #1;
    chk("eret_instr", instr_F, 32'd0);
    chk("eret_bd", 32'(BD_F), 32'd0);
    chk("eret_adel", 32'(adEL_F), 32'd0);
    tick(); idle(); #1;
    chk("eret_pc", pc_F, 32'h3040);
    chk("eret_fc", fetch_count, 32'd8);

    // Misaligned redirect
    redirect_D = 1; redirect_target = 32'h3102;
    tick(); idle(); #1;
    chk("mis_pc", pc_F, 32'h3102);
    chk("mis_adel", 32'(adEL_F), 32'd1);
    chk("mis_instr", instr_F, 32'd0);
    chk("mis_addr", i_inst_addr, 32'h3100);
    chk("mis_fc0", fetch_count, 32'd9);
    redirect_D = 1; redirect_target = 32'h7000;
    tick(); idle(); #1;
    chk("mis_fc1", fetch_count, 32'd9);

    // Out-of-range aligned fetch
    chk("rng_pc", pc_F, 32'h7000);
    chk("rng_adel", 32'(adEL_F), 32'(RC));
    chk("rng_instr", instr_F, RC ? 32'd0 : (32'h7000 ^ K));
    exp_fc = RC ? 32'd9 : 32'd10;
    tick();
    chk("rng_fc", fetch_count, exp_fc);

    // PC wrap at the top of the address space
    redirect_D = 1; redirect_target = 32'hFFFF_FFFC;
    tick(); idle(); #1;
    chk("wrap_pc0", pc_F, 32'hFFFF_FFFC);
    tick();
    chk("wrap_pc1", pc_F, 32'h0000_0000);

    // Reset beats simultaneous req and redirect
    reset = 1; req = 1; redirect_D = 1; redirect_target = 32'h3200;
    tick(); reset = 0; idle(); #1;
    chk("rr_pc", pc_F, 32'h3000);
    chk("rr_fc", fetch_count, 32'd0);
    tick();
    chk("rr_pc1", pc_F, 32'h3004);
    chk("rr_fc1", fetch_count, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
- Instruction-fetch stage of the P7 five-stage MIPS pipeline; sits directly upstream of the F/D pipeline register.
- Owns the architectural fetch PC and drives the instruction-memory address.
- Each cycle presents pc_F, instr_F, BD_F and adEL_F to the F/D register.
- Applies redirects in strict priority: exception entry, ERET return, taken branch/jump from D, sequential +4.

Parameters:
RESET_PC, 32'h0000_3000, PC loaded on reset
EXC_PC, 32'h0000_4180, exception/interrupt handler entry
IM_LO, 32'h0000_3000, lowest legal fetch address (range check)
IM_HI, 32'h0000_6ffc, highest legal fetch address (range check)

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
stall  input  1  hazard stall from D; hold PC
req  input  1  CP0 exception/interrupt request; overrides stall
eret_D  input  1  ERET currently in D
epc  input  32  return address from CP0
redirect_D  input  1  taken branch/jump resolved in D
redirect_target  input  32  target of redirect_D
branch_D  input  1  any branch/jump in D, taken or not
i_inst_rdata  input  32  instruction memory read data (combinational)
i_inst_addr  output  32  instruction memory address, {pc[31:2],2'b00}
pc_F  output  32  current fetch PC
instr_F  output  32  fetched instruction, or 0 when squashed/faulting
BD_F  output  1  fetched instruction is in a branch delay slot
adEL_F  output  1  fetch address error
fetch_count  output  32  count of valid instructions handed to F/D

Behaviour:
- State: pc register (32b) and fetch_count register (32b).
- reset: pc <= RESET_PC; fetch_count <= 0.
- Outputs are combinational from pc and inputs. Immediately after reset: pc_F=0x3000, adEL_F=0, BD_F=branch_D, instr_F=i_inst_rdata.
- Next-PC priority per edge, highest first:
  - reset
  - req: pc <= EXC_PC, even if stall=1
  - stall: pc held
  - eret_D: pc <= epc
  - redirect_D: pc <= redirect_target
  - otherwise: pc <= pc + 4, wrapping mod 2^32
- Delayed branch: a branch in D implies F already holds its delay slot, so redirect_D loads the target directly. BD_F = branch_D, combinational; F/D holds it during stall.
- ERET has no delay slot. While eret_D=1, instr_F = 0 (nop), BD_F = 0, adEL_F = 0, so the wrong-path instruction becomes a bubble.
- If eret_D and redirect_D are both 1, eret_D wins.
- adEL_F = (pc[1:0] != 0), OR-ed with the range term when the optional feature is enabled. When adEL_F=1: instr_F = 0 and i_inst_addr stays word-aligned. The fault is only reported; exception entry arrives later via req.
- fetch_count increments by 1 on an edge where reset=0, req=0, stall=0, eret_D=0 and adEL_F=0. It wraps at 2^32.
- Simultaneous req and stall: req wins, PC goes to EXC_PC; fetch_count does not increment.
- A reset asserted mid-operation discards any pending redirect. The next cycle fetches RESET_PC.

Optional Feature:
- Macro: IFU_RANGE_CHECK_EN
- Defined: adEL_F also asserts when pc < IM_LO or pc > IM_HI, unsigned compare on the full 32 bits.
- Undefined: only misalignment raises adEL_F; out-of-range aligned addresses pass through to instruction memory unchanged.

Test Plan:
- Reset, then 3 free-running cycles with no stall: pc_F = 0x3000, 0x3004, 0x3008, 0x300c; fetch_count = 3 at the 4th cycle.
- At pc 0x3010, branch_D=1, redirect_D=1, target=0x3100: BD_F=1 while pc_F=0x3010, next pc_F=0x3100 with BD_F=0.
- stall=1 for 2 cycles at pc 0x3020, then req=1 with stall=1: pc holds 0x3020 for both stall cycles, then becomes 0x4180; fetch_count unchanged across these cycles.
- eret_D=1, epc=0x3040, redirect_D=1 (target 0x3200) at pc 0x4188: instr_F=0, BD_F=0; next pc_F=0x3040.
- redirect to 0x3102: adEL_F=1, instr_F=0, i_inst_addr=0x3100, fetch_count not incremented. With IFU_RANGE_CHECK_EN, redirect to 0x7000 gives adEL_F=1; without it, adEL_F=0.
- reset asserted in the same cycle as req and redirect_D: next pc_F = 0x3000, fetch_count = 0.
